uart_queue_engine: RTL

UART-side queue engine acting as device A of the shared UART RAM multiplexer. Writes received UART bytes into a 256-entry RX ring in the high half of the RAM, and drains a 256-entry TX ring in the low half into the UART transmitter. Exchanges ring pointers with the CPU-side device (device B), which produces TX bytes and consumes RX bytes.

---
 rtl/uart_queue_engine_if.sv | 31 +++
 rtl/uart_queue_engine.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_queue_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_queue_engine_if
// Description : Device-A port of the shared UART RAM multiplexer. The engine
//               reads TX bytes from the low half and writes RX bytes into the
//               high half through this bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_queue_engine_if;
    logic [7:0] o_r_addr;   // read address (low half)
    logic       o_re;       // read enable
    logic [7:0] i_r_data;   // read data, valid with i_ack_r
    logic       i_ack_r;    // read ack, one clock after o_re
    logic [7:0] o_w_addr;   // write address (high half)
    logic [7:0] o_w_data;   // write data
    logic       o_we;       // write enable
    logic       i_ack_w;    // write ack, same clock as o_we

    // Engine side drives addresses and enables.
    modport master (
        output o_r_addr, o_re, o_w_addr, o_w_data, o_we,
        input  i_r_data, i_ack_r, i_ack_w
    );

    // Multiplexer side returns data and acknowledges.
    modport slave (
        input  o_r_addr, o_re, o_w_addr, o_w_data, o_we,
        output i_r_data, i_ack_r, i_ack_w
    );
endinterface
`default_nettype wire

// File: rtl/uart_queue_engine.sv
`default_nettype none
// ============================================================================
// Module      : uart_queue_engine
// Description : UART-side queue engine (device A). Writes received bytes into
//               a 256-entry RX ring in the high RAM half and drains a 256-entry
//               TX ring in the low RAM half into the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_queue_engine (
    input  wire logic                  i_clk,
    input  wire logic                  i_reset,
    uart_queue_engine_if.master        mux,
    input  wire logic [7:0]            i_rx_data,
    input  wire logic                  i_rx_valid,
    output logic      [7:0]            o_tx_data,
    output logic                       o_tx_start,
    input  wire logic                  i_tx_busy,
    output logic      [7:0]            o_rx_wr_ptr,
    input  wire logic [7:0]            i_rx_rd_ptr,
    input  wire logic [7:0]            i_tx_wr_ptr,
    output logic      [7:0]            o_tx_rd_ptr,
    output logic                       o_rx_overflow,
    input  wire logic                  i_overflow_clr
);

    // TX sequencer states.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_RWAIT = 3'd2;
    localparam logic [2:0] S_GUARD = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [7:0] r_hold_data;
    logic       r_hold_valid;
    logic [7:0] r_rx_wr_ptr;
    logic       r_rx_overflow;

    logic       w_rx_full;
    logic       w_we;
    logic       w_wr_done;
    logic       w_capture;
    logic       w_drop;

    // Ring is full when one more write would make the pointers equal.
    assign w_rx_full = ((r_rx_wr_ptr + 8'd1) == i_rx_rd_ptr);
    assign w_we      = r_hold_valid & ~w_rx_full;
    assign w_wr_done = w_we & mux.i_ack_w;
    // A byte fits if the holding slot is empty or is being emptied this cycle.
    assign w_capture = i_rx_valid & (~r_hold_valid | w_wr_done);
    assign w_drop    = i_rx_valid & r_hold_valid & ~w_wr_done;

    // Holding register, RX write pointer and sticky overflow flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold_data   <= 8'd0;
            r_hold_valid  <= 1'b0;
            r_rx_wr_ptr   <= 8'd0;
            r_rx_overflow <= 1'b0;
        end else begin
            if (w_capture) begin
                r_hold_data  <= i_rx_data;
                r_hold_valid <= 1'b1;
            end else if (w_wr_done) begin
                r_hold_valid <= 1'b0;
            end

            if (w_wr_done) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + 8'd1;
            end

            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_rx_overflow <= 1'b1;
            end else if (i_overflow_clr) begin
                r_rx_overflow <= 1'b0;
            end
        end
    end

    assign mux.o_we      = w_we;
    assign mux.o_w_addr  = r_rx_wr_ptr;
    assign mux.o_w_data  = r_hold_data;
    assign o_rx_wr_ptr   = r_rx_wr_ptr;
    assign o_rx_overflow = r_rx_overflow;

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       w_re;
    logic       w_tx_accept;
    logic [7:0] r_tx_rd_ptr;
    logic [7:0] r_tx_data;
    logic       r_tx_start;

    // TX sequencer state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // TX next-state and read-request decode. Acks outside RWAIT (including
    // the duplicate caused by RE staying high during RWAIT) are ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_re        = 1'b0;
        w_tx_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_tx_rd_ptr != i_tx_wr_ptr) && !i_tx_busy) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_re        = 1'b1;
                w_state_nxt = S_RWAIT;
            end
            S_RWAIT: begin
                w_re = 1'b1;
                if (mux.i_ack_r) begin
                    w_tx_accept = 1'b1;
                    w_state_nxt = S_GUARD;
                end
            end
            S_GUARD: begin
                // Gives the transmitter one cycle to raise busy.
                w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!i_tx_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the fetched byte, pulse start and advance the TX read pointer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_rd_ptr <= 8'd0;
            r_tx_data   <= 8'd0;
            r_tx_start  <= 1'b0;
        end else begin
            r_tx_start <= w_tx_accept;
            if (w_tx_accept) begin
                r_tx_data   <= mux.i_r_data;
                r_tx_rd_ptr <= r_tx_rd_ptr + 8'd1;
            end
        end
    end

    assign mux.o_re     = w_re;
    assign mux.o_r_addr = r_tx_rd_ptr;
    assign o_tx_rd_ptr  = r_tx_rd_ptr;
    assign o_tx_data    = r_tx_data;
    assign o_tx_start   = r_tx_start;

endmodule
`default_nettype wire
